// File: rtl/alu8_top.sv
// alu8_top: sequential 8-bit ALU (add, sub, Booth signed multiply,
// non-restoring unsigned divide) behind a start/done handshake.
module alu8_top (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op_code,
    input  logic [7:0]  operand_A,
    input  logic [7:0]  operand_B,
    output logic [15:0] alu_result,
    output logic        alu_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDSUB,
        S_MUL,
        S_DIV,
        S_DIV_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Operands captured at the accepting edge
    logic [1:0]        op_q;
    logic [7:0]        a_q;
    logic [7:0]        b_q;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;

    // Booth multiplier registers
    logic signed [8:0] ac;
    logic [7:0]        mq;
    logic              q_m1;

    // Divider registers
    logic signed [8:0] rem;
    logic [7:0]        dq;

    // Combinational datapath signals
    logic [7:0]        as_sum;
    logic signed [8:0] a_sext;
    logic signed [8:0] ac_sum;
    logic signed [8:0] ac_nxt;
    logic [7:0]        mq_nxt;
    logic              q_m1_nxt;
    logic signed [8:0] b_ext;
    logic signed [8:0] rem_sh;
    logic signed [8:0] rem_it;
    logic [7:0]        dq_nxt;
    logic [7:0]        rem_fix;
    logic [15:0]       result_mux;
    logic              load_result;

    // Add/subtract: subtraction is A + ~B + 1, carry/borrow dropped
    assign as_sum = a_q + (op_q[0] ? ~b_q : b_q) + {7'd0, op_q[0]};

    assign cnt_nxt = cnt - 4'd1;

    // Booth step: add/subtract sign-extended A from the 9-bit AC, then shift
    // the {AC, Q, q-1} chain arithmetically right by one.  The ninth AC bit
    // keeps -128 * -128 from overflowing the accumulator.
    assign a_sext = $signed({a_q[7], a_q});

    // Booth recoding of {Q[0], q-1}
    always_comb begin
        ac_sum = ac;
        case ({mq[0], q_m1})
            2'b01:   ac_sum = ac + a_sext;
            2'b10:   ac_sum = ac - a_sext;
            default: ac_sum = ac;
        endcase
    end

    assign ac_nxt   = $signed({ac_sum[8], ac_sum[8:1]});
    assign mq_nxt   = {ac_sum[0], mq[7:1]};
    assign q_m1_nxt = mq[0];

    // Non-restoring divide step.  R may exceed the 9-bit range only in the
    // shifted intermediate; the post-add value always fits, so the modular
    // arithmetic stays exact and the sign decision uses the pre-shift R.
    assign b_ext   = $signed({1'b0, b_q});
    assign rem_sh  = $signed({rem[7:0], dq[7]});
    assign rem_it  = rem[8] ? (rem_sh + b_ext) : (rem_sh - b_ext);
    assign dq_nxt  = {dq[6:0], ~rem_it[8]};
    // Final correction leaves a non-negative remainder below B
    assign rem_fix = rem[8] ? (rem[7:0] + b_q) : rem[7:0];

    // 4:1 result select by latched opcode
    always_comb begin
        result_mux = 16'h0000;
        case (op_q)
            2'b00, 2'b01: result_mux = {8'h00, as_sum};
            2'b10:        result_mux = {ac_nxt[7:0], mq_nxt};
            default:      result_mux = {rem_fix, dq};
        endcase
    end

    // Result is captured only on the edge that enters DONE
    assign load_result = (state_nxt == S_DONE) && (state != S_DONE);
    assign alu_done    = (state == S_DONE);

    // Control FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Control FSM next-state logic; start only matters in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op_code)
                        2'b10:   state_nxt = S_MUL;
                        2'b11:   state_nxt = S_DIV;
                        default: state_nxt = S_ADDSUB;
                    endcase
                end
            end
            S_ADDSUB:  state_nxt = S_DONE;
            S_MUL:     if (cnt_nxt == 4'd0) state_nxt = S_DONE;
            S_DIV:     if (cnt_nxt == 4'd0) state_nxt = S_DIV_FIX;
            S_DIV_FIX: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Operand capture and iterative datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= 2'b00;
            a_q  <= 8'h00;
            b_q  <= 8'h00;
            cnt  <= 4'd0;
            ac   <= 9'sd0;
            mq   <= 8'h00;
            q_m1 <= 1'b0;
            rem  <= 9'sd0;
            dq   <= 8'h00;
        end else if (state == S_IDLE && start) begin
            op_q <= op_code;
            a_q  <= operand_A;
            b_q  <= operand_B;
            cnt  <= 4'd8;
            ac   <= 9'sd0;
            mq   <= operand_B;
            q_m1 <= 1'b0;
            rem  <= 9'sd0;
            dq   <= operand_A;
        end else if (state == S_MUL) begin
            ac   <= ac_nxt;
            mq   <= mq_nxt;
            q_m1 <= q_m1_nxt;
            cnt  <= cnt_nxt;
        end else if (state == S_DIV) begin
            rem  <= rem_it;
            dq   <= dq_nxt;
            cnt  <= cnt_nxt;
        end else if (state == S_DIV_FIX) begin
            rem  <= $signed({1'b0, rem_fix});
        end
    end

    // Result register, held between completions
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            alu_result <= 16'h0000;
        else if (load_result) alu_result <= result_mux;
    end

endmodule

// File: tb/tb_alu8_top.sv
// tb_alu8_top: directed-vector bench for alu8_top.
module tb_alu8_top;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op_code;
    logic [7:0]  operand_A;
    logic [7:0]  operand_B;
    logic [15:0] alu_result;
    logic        alu_done;

    int n_chk = 0;
    int n_bad = 0;

    alu8_top dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_code    (op_code),
        .operand_A  (operand_A),
        .operand_B  (operand_B),
        .alu_result (alu_result),
        .alu_done   (alu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Count edges after the accepting edge until alu_done, bounded
    task automatic wait_done(output int n);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (alu_done) break;
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp, input int lat);
        int n;
        @(negedge clk);
        op_code = op; operand_A = a; operand_B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        chk({tag, "_lat"}, 16'(n), 16'(lat));
        chk({tag, "_res"}, alu_result, exp);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {15'd0, alu_done}, 16'd0);
        chk({tag, "_hold"}, alu_result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        logic        exp_done [5];
        logic [15:0] exp_res  [5];

        reset = 1'b1; start = 1'b0; op_code = 2'b00; operand_A = 8'h00; operand_B = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res", alu_result, 16'h0000);
        chk("rst_done", {15'd0, alu_done}, 16'd0);
        @(negedge clk); reset = 1'b0;

        do_op("add_15_10",  2'b00, 8'd15,  8'd10,  16'h0019, 1);
        do_op("sub_25_10",  2'b01, 8'd25,  8'd10,  16'h000F, 1);
        do_op("sub_10_25",  2'b01, 8'd10,  8'd25,  16'h00F1, 1);
        do_op("add_carry",  2'b00, 8'd200, 8'd100, 16'h002C, 1);
        do_op("mul_5_6",    2'b10, 8'd5,   8'd6,   16'h001E, 8);
        do_op("mul_m3_7",   2'b10, 8'hFD,  8'd7,   16'hFFEB, 8);
        do_op("mul_m128sq", 2'b10, 8'h80,  8'h80,  16'h4000, 8);
        do_op("mul_127_m128", 2'b10, 8'h7F, 8'h80, 16'hC080, 8);
        do_op("div_40_6",   2'b11, 8'd40,  8'd6,   16'h0406, 9);
        do_op("div_40_0",   2'b11, 8'd40,  8'd0,   16'h28FF, 9);
        do_op("div_255_16", 2'b11, 8'd255, 8'd16,  16'h0F0F, 9);
        do_op("div_5_200",  2'b11, 8'd5,   8'd200, 16'h0500, 9);

        // Disturb inputs and pulse start while a MUL runs
        @(negedge clk);
        op_code = 2'b10; operand_A = 8'd5; operand_B = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        op_code = 2'b00; operand_A = 8'hAA; operand_B = 8'h55; start = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(n);
        chk("mul_disturb_lat", 16'(n + 2), 16'd8);
        chk("mul_disturb_res", alu_result, 16'h001E);
        @(posedge clk); #1;
        chk("mul_disturb_pulse", {15'd0, alu_done}, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("mul_disturb_idle", {15'd0, alu_done}, 16'd0);

        // Reset in the middle of a DIV
        @(negedge clk);
        op_code = 2'b11; operand_A = 8'd40; operand_B = 8'd6; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #2; reset = 1'b1;
        #1;
        chk("midrst_res", alu_result, 16'h0000);
        chk("midrst_done", {15'd0, alu_done}, 16'd0);
        @(negedge clk); reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (alu_done) seen++;
        end
        chk("midrst_no_done", 16'(seen), 16'd0);
        chk("midrst_res_kept", alu_result, 16'h0000);
        do_op("add_after_rst", 2'b00, 8'd15, 8'd10, 16'h0019, 1);

        // Start held high: ADD then SUB back-to-back
        exp_done = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_res  = '{16'h0007, 16'h0007, 16'h0007, 16'h000F, 16'h000F};
        @(negedge clk);
        op_code = 2'b00; operand_A = 8'd3; operand_B = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        op_code = 2'b01; operand_A = 8'd20; operand_B = 8'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 3) start = 1'b0;
            chk($sformatf("b2b_done_%0d", i + 1), {15'd0, alu_done}, {15'd0, exp_done[i]});
            chk($sformatf("b2b_res_%0d", i + 1), alu_result, exp_res[i]);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_stop", {15'd0, alu_done}, 16'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
